addr_seq_ctrl: RTL and testbench
================================

# addr_seq_ctrl

Sequencer for the ASIP MAX/MIN/AVG datapath. It takes a start command with base address, element count, result address and opcode. It walks the operand block through the data-memory address path, marks each returned operand for the ALU, then steers the address 2:1 mux to the temporary/result address for a single write-back. It sits between the instruction decoder (command side) and the address mux, data memory and ALU (datapath side).

## Interface
- AW, 8, address width (ADD_R / TEMP_ADD_R width)
- CW, 8, element-count width
- CLK  in  1  clock, all state on rising edge
- RST_n  in  1  synchronous, active-low reset
- START  in  1  command strobe, sampled only in IDLE
- BASE_ADDR  in  AW  first operand address
- COUNT  in  CW  number of operands (0 allowed)
- RESULT_ADDR  in  AW  write-back address
- OP  in  2  00=MAX, 01=MIN, 10=AVG, 11=reserved (treated as MAX)
- ADD_R_out  out  AW  operand address to mux input 0
- TEMP_ADD_R_out  out  AW  result address to mux input 1
- Select_line  out  1  0 = operand address, 1 = result address
- MEM_RD  out  1  memory read strobe
- MEM_WR  out  1  memory write strobe
- ALU_OP  out  2  OP latched at START
- ALU_VALID  out  1  operand on memory data bus valid this cycle
- ALU_FIRST  out  1  with ALU_VALID: first operand, so the ALU loads instead of accumulating
- ALU_LAST  out  1  with ALU_VALID: final operand
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, DRAIN, WRITE, FINISH.
- IDLE, START=1, COUNT≠0:
  - Latch BASE_ADDR, COUNT, RESULT_ADDR, OP.
  - Go to READ; element index i=0.
- IDLE, START=1, COUNT=0:
  - Go directly to FINISH.
  - No MEM_RD, MEM_WR or ALU_VALID is ever issued.
- READ:
  - MEM_RD=1, Select_line=0, ADD_R_out = BASE+i, modulo 2^AW (wraps 0xFF→0x00).
  - On i = COUNT−1, go to DRAIN; else i++.
- DRAIN (one cycle):
  - No memory access.
  - Covers the 1-cycle memory read latency so the last operand reaches the ALU.
- WRITE (one cycle):
  - Select_line=1, MEM_WR=1, TEMP_ADD_R_out = RESULT_ADDR.
- FINISH (one cycle):
  - DONE=1, then IDLE.
- ALU_VALID/FIRST/LAST are MEM_RD and the i=0 / i=COUNT−1 flags, each delayed one register stage.
- BUSY=1 in every state except IDLE. DONE and BUSY are both 1 in FINISH.
- TEMP_ADD_R_out holds the latched RESULT_ADDR from START until the next accepted START.
- START outside IDLE is ignored; inputs are not re-latched.
- Count/index arithmetic is CW bits. COUNT=255 gives 255 reads.
- Reset:
  - All outputs 0 (addresses 0x00, ALU_OP 00, Select_line 0), state IDLE.
  - Reset mid-command aborts it: no write-back, no DONE.

## Timing
- START accepted at edge 0. READ of element i occupies cycle 1+i.
- ALU_VALID for element i in cycle 2+i.
- DRAIN in cycle COUNT+1, which also carries ALU_VALID for the last element with ALU_LAST=1.
- WRITE in cycle COUNT+2. FINISH/DONE in cycle COUNT+3.
- Total latency START→DONE = COUNT+3 cycles. COUNT=0 gives DONE in cycle 1.
- Earliest next START is accepted the cycle after DONE (IDLE).
- MEM_RD and MEM_WR are never high together.
- Select_line=1 only in WRITE.
- All outputs are registered; no combinational input→output path.

## Structure
- Shared package asip_pkg holds:
  - state enum (IDLE, READ, DRAIN, WRITE, FINISH)
  - OP codes (OP_MAX, OP_MIN, OP_AVG)
  - AW/CW defaults
- Single module; no sub-module needed. The address mux, memory and ALU remain external.
- Index counter and address adder are inline.

## Test plan
- BASE=0x10, COUNT=4, RESULT=0x80, OP=MAX:
  - reads at 0x10..0x13 in cycles 1–4
  - ALU_VALID cycles 2–5; FIRST in cycle 2, LAST in cycle 5
  - WRITE in cycle 6 with Select_line=1, TEMP_ADD_R_out=0x80
  - DONE in cycle 7
- BASE=0xFE, COUNT=3 → ADD_R_out sequence 0xFE, 0xFF, 0x00; write-back still issued once.
- COUNT=0, START=1 → DONE in cycle 1, BUSY high one cycle, zero MEM_RD/MEM_WR/ALU_VALID.
- COUNT=1, OP=AVG:
  - one read at BASE
  - ALU_VALID with FIRST=LAST=1 in cycle 2
  - ALU_OP=10 throughout; DONE in cycle 4
- START pulsed again during READ with different BASE → ignored; original address sequence and DONE timing unchanged.
- RST_n=0 during READ of COUNT=8 → next cycle all outputs 0, state IDLE, no MEM_WR or DONE; fresh START then runs normally.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared types and defaults for the ASIP MAX/MIN/AVG address sequencer.
// Holds the sequencer state enum, ALU opcodes and default address/count widths.
package asip_pkg;

  localparam int AW_DEF = 8;
  localparam int CW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  localparam logic [1:0] OP_MAX = 2'b00;
  localparam logic [1:0] OP_MIN = 2'b01;
  localparam logic [1:0] OP_AVG = 2'b10;

  // The reserved code 11 is folded onto MAX so the ALU never sees it.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    norm_op = (op == 2'b11) ? OP_MAX : op;
  endfunction

endpackage

// File: rtl/addr_seq_ctrl.sv
// Address sequencer: walks an operand block, tags operands for the ALU,
// then steers the address mux to the result address for one write-back.
// Ports:
//   CLK, RST_n (sync, active-low)
//   START, BASE_ADDR, COUNT, RESULT_ADDR, OP    : command from decoder
//   ADD_R_out, TEMP_ADD_R_out, Select_line      : address mux inputs/select
//   MEM_RD, MEM_WR                              : data memory strobes
//   ALU_OP, ALU_VALID, ALU_FIRST, ALU_LAST      : ALU control
//   BUSY, DONE                                  : status
module addr_seq_ctrl
  import asip_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [CW-1:0] COUNT,
  input  logic [AW-1:0] RESULT_ADDR,
  input  logic [1:0]    OP,
  output logic [AW-1:0] ADD_R_out,
  output logic [AW-1:0] TEMP_ADD_R_out,
  output logic          Select_line,
  output logic          MEM_RD,
  output logic          MEM_WR,
  output logic [1:0]    ALU_OP,
  output logic          ALU_VALID,
  output logic          ALU_FIRST,
  output logic          ALU_LAST,
  output logic          BUSY,
  output logic          DONE
);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] res_q, res_d;
  logic [1:0]    op_q, op_d;

  logic [AW-1:0] add_r_q, add_r_d;
  logic          sel_q, sel_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_first_q, rd_first_d;
  logic          rd_last_q, rd_last_d;
  logic          valid_q, first_q, last_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    res_d   = res_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          base_d  = BASE_ADDR;
          cnt_d   = COUNT;
          res_d   = RESULT_ADDR;
          op_d    = norm_op(OP);
          idx_d   = '0;
          state_d = (COUNT == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (idx_q == cnt_q - CW'(1)) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DRAIN:  state_d = S_WRITE;
      S_WRITE:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops
  // aligned with the state they describe.
  always_comb begin
    rd_d       = (state_d == S_READ);
    wr_d       = (state_d == S_WRITE);
    sel_d      = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    rd_first_d = rd_d && (idx_d == '0);
    rd_last_d  = rd_d && (idx_d == cnt_d - CW'(1));
    add_r_d    = add_r_q;
    if (rd_d) begin
      add_r_d = base_d + AW'(idx_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      res_q      <= '0;
      op_q       <= OP_MAX;
      add_r_q    <= '0;
      sel_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      res_q      <= res_d;
      op_q       <= op_d;
      add_r_q    <= add_r_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      // One-cycle memory read latency: operand arrives a cycle after MEM_RD.
      valid_q    <= rd_q;
      first_q    <= rd_first_q;
      last_q     <= rd_last_q;
    end
  end

  assign ADD_R_out      = add_r_q;
  assign TEMP_ADD_R_out = res_q;
  assign Select_line    = sel_q;
  assign MEM_RD         = rd_q;
  assign MEM_WR         = wr_q;
  assign ALU_OP         = op_q;
  assign ALU_VALID      = valid_q;
  assign ALU_FIRST      = first_q;
  assign ALU_LAST       = last_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl.
// Directed and random commands checked cycle by cycle against a timing model.
module tb_addr_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] count;
  logic [7:0] result_addr;
  logic [1:0] op;
  logic [7:0] add_r_out;
  logic [7:0] temp_add_r_out;
  logic       select_line;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] alu_op;
  logic       alu_valid;
  logic       alu_first;
  logic       alu_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  addr_seq_ctrl dut (
    .CLK            (clk),
    .RST_n          (rst_n),
    .START          (start),
    .BASE_ADDR      (base_addr),
    .COUNT          (count),
    .RESULT_ADDR    (result_addr),
    .OP             (op),
    .ADD_R_out      (add_r_out),
    .TEMP_ADD_R_out (temp_add_r_out),
    .Select_line    (select_line),
    .MEM_RD         (mem_rd),
    .MEM_WR         (mem_wr),
    .ALU_OP         (alu_op),
    .ALU_VALID      (alu_valid),
    .ALU_FIRST      (alu_first),
    .ALU_LAST       (alu_last),
    .BUSY           (busy),
    .DONE           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control bits in cycle k after START for an n-element command:
  // {MEM_RD, ALU_VALID, ALU_FIRST, ALU_LAST, MEM_WR, Select_line, BUSY, DONE}
  function automatic logic [7:0] model(input int k, input int n);
    int  dc;
    bit  rd, vl, fi, la, wr, bz, dn;
    dc = (n == 0) ? 1 : n + 3;
    rd = (n > 0) && (k >= 1) && (k <= n);
    vl = (n > 0) && (k >= 2) && (k <= n + 1);
    fi = vl && (k == 2);
    la = vl && (k == n + 1);
    wr = (n > 0) && (k == n + 2);
    bz = (k >= 1) && (k <= dc);
    dn = (k == dc);
    model = {rd, vl, fi, la, wr, wr, bz, dn};
  endfunction

  function automatic logic [1:0] exp_op(input logic [1:0] o);
    exp_op = (o == 2'b11) ? 2'b00 : o;
  endfunction

  // kick: cycle in which a second START with other inputs is pulsed.
  // abort: cycle in which reset is asserted (0 = never).
  task automatic run_cmd(input logic [7:0] b, input logic [7:0] n,
                         input logic [7:0] r, input logic [1:0] o,
                         input int kick, input int abort, input string tag);
    int          last_k;
    int          nn;
    logic [7:0]  got;
    logic [7:0]  exp;
    logic [7:0]  ea;
    nn = int'(n);
    last_k = (nn == 0) ? 2 : nn + 4;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    count = n;
    result_addr = r;
    op = o;
    @(negedge clk);
    for (int k = 1; k <= last_k; k++) begin
      got = {mem_rd, alu_valid, alu_first, alu_last,
             mem_wr, select_line, busy, done};
      exp = model(k, nn);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s ctl cyc%0d got=%b exp=%b", tag, k, got, exp);
      end
      if (exp[7]) begin
        ea = b + 8'(k - 1);
        n_cmp++;
        if (add_r_out !== ea) begin
          n_err++;
          $display("FAIL %s addr cyc%0d got=%h exp=%h", tag, k, add_r_out, ea);
        end
      end
      n_cmp++;
      if (temp_add_r_out !== r || alu_op !== exp_op(o)) begin
        n_err++;
        $display("FAIL %s latch cyc%0d got=%h/%b exp=%h/%b", tag, k,
                 temp_add_r_out, alu_op, r, exp_op(o));
      end
      if (k == abort) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        got = {mem_rd, alu_valid, alu_first, alu_last,
               mem_wr, select_line, busy, done};
        n_cmp++;
        if (got !== 8'h00 || add_r_out !== 8'h00 ||
            temp_add_r_out !== 8'h00 || alu_op !== 2'b00) begin
          n_err++;
          $display("FAIL %s abort ctl=%b a=%h t=%h op=%b exp=0", tag, got,
                   add_r_out, temp_add_r_out, alu_op);
        end
        rst_n = 1'b1;
        for (int j = 0; j < nn + 4; j++) begin
          @(negedge clk);
          n_cmp++;
          if (mem_wr !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s post_abort cyc%0d wr=%b done=%b busy=%b exp=0",
                     tag, j, mem_wr, done, busy);
          end
        end
        return;
      end
      start = (k == kick);
      base_addr = b ^ 8'h5A;
      count = 8'($urandom_range(1, 9));
      result_addr = ~r;
      op = ~o;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    base_addr = 8'hAA;
    count = 8'd5;
    result_addr = 8'h55;
    op = 2'b01;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({add_r_out, temp_add_r_out, select_line, mem_rd, mem_wr, alu_op,
         alu_valid, alu_first, alu_last, busy, done} !== 29'd0) begin
      n_err++;
      $display("FAIL reset a=%h t=%h sel=%b rd=%b wr=%b op=%b busy=%b done=%b exp=0",
               add_r_out, temp_add_r_out, select_line, mem_rd, mem_wr,
               alu_op, busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_cmd(8'h10, 8'd4, 8'h80, 2'b00, 0, 0, "basic");
  endtask

  task automatic test_wrap();
    run_cmd(8'hFE, 8'd3, 8'h22, 2'b01, 0, 0, "wrap");
  endtask

  task automatic test_zero_count();
    run_cmd(8'h40, 8'd0, 8'h41, 2'b10, 0, 0, "zero");
  endtask

  task automatic test_single_avg();
    run_cmd(8'h33, 8'd1, 8'h90, 2'b10, 0, 0, "single");
  endtask

  task automatic test_restart_ignored();
    run_cmd(8'h20, 8'd5, 8'hC0, 2'b01, 2, 0, "restart");
    run_cmd(8'h70, 8'd2, 8'hC4, 2'b00, 5, 0, "restart_fin");
  endtask

  task automatic test_abort();
    run_cmd(8'h50, 8'd8, 8'hE0, 2'b10, 3, 3, "abort");
    run_cmd(8'h60, 8'd3, 8'hE8, 2'b01, 0, 0, "after_abort");
  endtask

  task automatic test_max_count();
    run_cmd(8'h80, 8'd255, 8'h07, 2'b11, 0, 0, "max");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) begin
      run_cmd(8'($urandom), 8'($urandom_range(0, 20)), 8'($urandom),
              2'($urandom), 0, 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_single_avg();
    test_restart_ignored();
    test_abort();
    test_max_count();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
